// File: rtl/key_conditioner.sv
// Conditions board buttons and switches: 2-FF synchronisers, per-input debounce,
// press pulses with cancel-over-submit priority, octave auto-repeat and one-hot note decode.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic [6:0] note_raw,
  input  logic [6:0] length_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse,
  output logic [1:0] oct_rep,
  output logic [6:0] note_key,
  output logic [6:0] length_key,
  output logic       note_valid,
  output logic [2:0] note_idx
);
  localparam int N_IN  = 18;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]      DELAY_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0]      PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rep_state_t;

  logic [N_IN-1:0]  sync_p0;
  logic [N_IN-1:0]  sync_p1;
  logic [N_IN-1:0]  stable_p2;
  logic [CNT_W-1:0] db_cnt_p2 [N_IN];
  logic [3:0]       level_prev_p3;
  logic [3:0]       rise_p2;
  logic             note_onehot;
  logic [2:0]       note_idx_d;

  // Stages 0-1: two-flop synchroniser; stage 2: debounce into the stable level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      stable_p2 <= '0;
      for (int i = 0; i < N_IN; i++) db_cnt_p2[i] <= '0;
    end else begin
      sync_p0 <= {length_raw, note_raw, btn_raw};
      sync_p1 <= sync_p0;
      for (int i = 0; i < N_IN; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          db_cnt_p2[i] <= '0;
        end else if (db_cnt_p2[i] == DB_LAST) begin
          stable_p2[i] <= sync_p1[i];
          db_cnt_p2[i] <= '0;
        end else begin
          db_cnt_p2[i] <= db_cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  assign btn_level  = stable_p2[3:0];
  assign note_key   = stable_p2[10:4];
  assign length_key = stable_p2[17:11];

  // A simultaneous submit press is dropped so the controller never sees both
  always_comb begin
    rise_p2 = stable_p2[3:0] & ~level_prev_p3;
    if (rise_p2[0] && rise_p2[1]) rise_p2[0] = 1'b0;
  end

  always_comb begin
    note_onehot = $onehot(note_key);
    note_idx_d  = 3'd7;
    for (int i = 0; i < 7; i++) begin
      if (note_onehot && note_key[i]) note_idx_d = 3'(i);
    end
  end

  // Stage 3: registered press pulses and note decode
  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_p3 <= '0;
      btn_pulse     <= '0;
      note_valid    <= 1'b0;
      note_idx      <= 3'd7;
    end else begin
      level_prev_p3 <= stable_p2[3:0];
      btn_pulse     <= rise_p2;
      note_valid    <= note_onehot;
      note_idx      <= note_idx_d;
    end
  end

  // Auto-repeat: g=0 follows oct_up (bit 2), g=1 follows oct_down (bit 3)
  for (genvar g = 0; g < 2; g++) begin : g_oct
    rep_state_t  state_q;
    rep_state_t  state_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        rep_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rep_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (btn_pulse[g+2]) begin
            rep_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (!btn_level[g+2]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DELAY_LAST) begin
            rep_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_REPEAT: begin
          if (!btn_level[g+2]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == PERIOD_LAST) begin
            rep_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign oct_rep[g] = rep_d;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short debounce/repeat timings; expected pulses are
// queued with their cycle stamp when stimulus is applied and compared every cycle.
module tb_key_conditioner;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  localparam logic [6:0] NOTE_VALS  [4] = '{7'b0000100, 7'b0000110, 7'b0000000, 7'b1000000};
  localparam logic       NOTE_VLD   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [2:0] NOTE_IDX   [4] = '{3'd2, 3'd7, 3'd7, 3'd6};
  localparam logic [5:0] BOUNCE_SEQ = 6'b101101;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic [6:0] note_raw;
  logic [6:0] length_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;
  logic [1:0] oct_rep;
  logic [6:0] note_key;
  logic [6:0] length_key;
  logic       note_valid;
  logic [2:0] note_idx;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         t;
    logic [3:0] v;
  } ev_t;

  ev_t pq[$];
  ev_t rq[$];

  key_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .note_raw  (note_raw),
    .length_raw(length_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .oct_rep   (oct_rep),
    .note_key  (note_key),
    .length_key(length_key),
    .note_valid(note_valid),
    .note_idx  (note_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(int t, logic [3:0] v);
    ev_t e;
    e.t = t;
    e.v = v;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    btn_raw    = '0;
    note_raw   = '0;
    length_raw = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pq.delete();
    rq.delete();
  endtask

  // Raw edge driven at cycle t0: level at t0+6 (2 sync + 4 debounce), pulse one cycle later
  task automatic test_reset();
    int t0;
    ev_t pe;
    logic [3:0] pe_v;
    logic [1:0] re_v;
    rst        = 1'b1;
    btn_raw    = '1;
    note_raw   = '1;
    length_raw = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({btn_level, btn_pulse, oct_rep, note_key, length_key, note_valid, note_idx} !==
        {4'h0, 4'h0, 2'b00, 7'h00, 7'h00, 1'b0, 3'd7}) begin
      errors++;
      $display("FAIL reset_state: got lvl=%b pls=%b rep=%b note=%b len=%b vld=%b idx=%0d, expected zeros with idx=7",
               btn_level, btn_pulse, oct_rep, note_key, length_key, note_valid, note_idx);
    end
    rst = 1'b0;
    t0  = cyc;
    // submit and cancel rise together, so cancel takes the cycle and submit is dropped
    pq.push_back(mk_ev(t0 + 7, 4'b1110));
    rq.push_back(mk_ev(t0 + 7, 4'b0011));
    repeat (14) begin
      @(negedge clk);
      pe_v = 4'd0;
      if (pq.size() != 0 && pq[0].t == cyc) begin pe = pq.pop_front(); pe_v = pe.v; end
      checks++;
      if (btn_pulse !== pe_v) begin
        errors++;
        $display("FAIL reset_btn_pulse cyc %0d: got %b expected %b", cyc - t0, btn_pulse, pe_v);
      end
      re_v = 2'd0;
      if (rq.size() != 0 && rq[0].t == cyc) begin pe = rq.pop_front(); re_v = pe.v[1:0]; end
      checks++;
      if (oct_rep !== re_v) begin
        errors++;
        $display("FAIL reset_oct_rep cyc %0d: got %b expected %b", cyc - t0, oct_rep, re_v);
      end
      checks++;
      if (btn_level !== ((cyc >= t0 + 6) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL reset_btn_level cyc %0d: got %b", cyc - t0, btn_level);
      end
    end
    checks++;
    if ({note_key, length_key, note_valid, note_idx} !== {7'h7F, 7'h7F, 1'b0, 3'd7} ||
        pq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL reset_after: got note=%b len=%b vld=%b idx=%0d pending=%0d, expected 7f 7f 0 7 0",
               note_key, length_key, note_valid, note_idx, pq.size() + rq.size());
    end
  endtask

  task automatic test_bounce();
    int tf;
    ev_t pe;
    logic [3:0] pe_v;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (btn_level !== 4'h0 || btn_pulse !== 4'h0) begin
        errors++;
        $display("FAIL bounce_early: got lvl=%b pls=%b expected 0000 0000", btn_level, btn_pulse);
      end
      btn_raw[0] = BOUNCE_SEQ[i];
    end
    tf = cyc;
    pq.push_back(mk_ev(tf + 7, 4'b0001));
    repeat (14) begin
      @(negedge clk);
      pe_v = 4'd0;
      if (pq.size() != 0 && pq[0].t == cyc) begin pe = pq.pop_front(); pe_v = pe.v; end
      checks++;
      if (btn_pulse !== pe_v) begin
        errors++;
        $display("FAIL bounce_btn_pulse cyc %0d: got %b expected %b", cyc - tf, btn_pulse, pe_v);
      end
      checks++;
      if (btn_level !== ((cyc >= tf + 6) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL bounce_btn_level cyc %0d: got %b", cyc - tf, btn_level);
      end
    end
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL bounce_pending: got %0d events left expected 0", pq.size());
    end
  endtask

  task automatic test_collision();
    int t0;
    ev_t pe;
    logic [3:0] pe_v;
    do_reset();
    @(negedge clk);
    btn_raw = 4'b0011;
    t0      = cyc;
    pq.push_back(mk_ev(t0 + 7, 4'b0010));
    repeat (14) begin
      @(negedge clk);
      pe_v = 4'd0;
      if (pq.size() != 0 && pq[0].t == cyc) begin pe = pq.pop_front(); pe_v = pe.v; end
      checks++;
      if (btn_pulse !== pe_v) begin
        errors++;
        $display("FAIL collision_btn_pulse cyc %0d: got %b expected %b", cyc - t0, btn_pulse, pe_v);
      end
      checks++;
      if (btn_level !== ((cyc >= t0 + 6) ? 4'b0011 : 4'b0000)) begin
        errors++;
        $display("FAIL collision_btn_level cyc %0d: got %b", cyc - t0, btn_level);
      end
    end
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL collision_pending: got %0d events left expected 0", pq.size());
    end
  endtask

  task automatic test_auto_repeat();
    int t0;
    ev_t pe;
    logic [3:0] pe_v;
    logic [1:0] re_v;
    int offs [7] = '{0, 10, 15, 20, 25, 30, 35};
    do_reset();
    @(negedge clk);
    btn_raw = 4'b0100;
    t0      = cyc;
    pq.push_back(mk_ev(t0 + 7, 4'b0100));
    foreach (offs[k]) rq.push_back(mk_ev(t0 + 7 + offs[k], 4'b0001));
    repeat (70) begin
      @(negedge clk);
      pe_v = 4'd0;
      if (pq.size() != 0 && pq[0].t == cyc) begin pe = pq.pop_front(); pe_v = pe.v; end
      checks++;
      if (btn_pulse !== pe_v) begin
        errors++;
        $display("FAIL repeat_btn_pulse cyc %0d: got %b expected %b", cyc - t0, btn_pulse, pe_v);
      end
      re_v = 2'd0;
      if (rq.size() != 0 && rq[0].t == cyc) begin pe = rq.pop_front(); re_v = pe.v[1:0]; end
      checks++;
      if (oct_rep !== re_v) begin
        errors++;
        $display("FAIL repeat_oct_rep offset %0d: got %b expected %b", cyc - t0 - 7, oct_rep, re_v);
      end
      checks++;
      if (btn_level !== ((cyc >= t0 + 6 && cyc < t0 + 46) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL repeat_btn_level cyc %0d: got %b", cyc - t0, btn_level);
      end
      // released so the debounced level drops at offset 39, just before the offset-40 tick
      if (cyc == t0 + 40) btn_raw = 4'b0000;
    end
    checks++;
    if (pq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL repeat_pending: got %0d events left expected 0", pq.size() + rq.size());
    end
  endtask

  task automatic test_note_decode();
    int t0;
    logic [6:0] prev_key;
    logic       prev_vld;
    logic [2:0] prev_idx;
    logic [6:0] exp_key;
    logic       exp_vld;
    logic [2:0] exp_idx;
    do_reset();
    prev_key = 7'd0;
    prev_vld = 1'b0;
    prev_idx = 3'd7;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      note_raw = NOTE_VALS[s];
      if (s == 0) length_raw = 7'b1010011;
      t0 = cyc;
      repeat (9) begin
        @(negedge clk);
        exp_key = (cyc >= t0 + 6) ? NOTE_VALS[s] : prev_key;
        exp_vld = (cyc >= t0 + 7) ? NOTE_VLD[s] : prev_vld;
        exp_idx = (cyc >= t0 + 7) ? NOTE_IDX[s] : prev_idx;
        checks++;
        if (note_key !== exp_key) begin
          errors++;
          $display("FAIL note_key step %0d cyc %0d: got %b expected %b", s, cyc - t0, note_key, exp_key);
        end
        checks++;
        if ({note_valid, note_idx} !== {exp_vld, exp_idx}) begin
          errors++;
          $display("FAIL note_decode step %0d cyc %0d: got vld=%b idx=%0d expected vld=%b idx=%0d",
                   s, cyc - t0, note_valid, note_idx, exp_vld, exp_idx);
        end
      end
      prev_key = NOTE_VALS[s];
      prev_vld = NOTE_VLD[s];
      prev_idx = NOTE_IDX[s];
    end
    checks++;
    if (length_key !== 7'b1010011) begin
      errors++;
      $display("FAIL length_key: got %b expected 1010011", length_key);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int t0;
    int t1;
    ev_t pe;
    logic [3:0] pe_v;
    logic [1:0] re_v;
    do_reset();
    @(negedge clk);
    btn_raw = 4'b0100;
    t0      = cyc;
    pq.push_back(mk_ev(t0 + 7, 4'b0100));
    rq.push_back(mk_ev(t0 + 7, 4'b0001));
    rq.push_back(mk_ev(t0 + 17, 4'b0001));
    rq.push_back(mk_ev(t0 + 22, 4'b0001));
    t1 = 0;
    for (int k = 0; k < 45; k++) begin
      if (k == 24) rst = 1'b1;
      @(negedge clk);
      if (k == 24) begin
        checks++;
        if ({btn_level, btn_pulse, oct_rep} !== 10'd0) begin
          errors++;
          $display("FAIL midrst_state: got lvl=%b pls=%b rep=%b expected all 0", btn_level, btn_pulse, oct_rep);
        end
        rst = 1'b0;
        t1  = cyc;
        pq.push_back(mk_ev(t1 + 7, 4'b0100));
        rq.push_back(mk_ev(t1 + 7, 4'b0001));
        rq.push_back(mk_ev(t1 + 17, 4'b0001));
      end
      pe_v = 4'd0;
      if (pq.size() != 0 && pq[0].t == cyc) begin pe = pq.pop_front(); pe_v = pe.v; end
      checks++;
      if (btn_pulse !== pe_v) begin
        errors++;
        $display("FAIL midrst_btn_pulse cyc %0d: got %b expected %b", cyc - t0, btn_pulse, pe_v);
      end
      re_v = 2'd0;
      if (rq.size() != 0 && rq[0].t == cyc) begin pe = rq.pop_front(); re_v = pe.v[1:0]; end
      checks++;
      if (oct_rep !== re_v) begin
        errors++;
        $display("FAIL midrst_oct_rep cyc %0d: got %b expected %b", cyc - t0, oct_rep, re_v);
      end
    end
    checks++;
    if (pq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL midrst_pending: got %0d events left expected 0", pq.size() + rq.size());
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_collision();
    test_auto_repeat();
    test_note_decode();
    test_reset_mid_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
